keypad_code_entry: RTL and testbench

//  Scans a 4x4 matrix keypad, debounces it and assembles up to 4 BCD digits into user_input.

---
 rtl/keypad_code_entry.sv | 212 +++++++++++++++++++++
 tb/tb_keypad_code_entry.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_code_entry.sv
// keypad_code_entry
//   Scans a 4x4 active-low matrix keypad one column at a time, debounces the
//   press and the release, and assembles up to four BCD digits for the LCD
//   driver and the safe's main FSM.
//
//   Configuration macro: KEYPAD_BACKSPACE_EN
//     defined   -> '*' removes the newest digit (no effect on an empty buffer)
//     undefined -> '*' clears the whole buffer
//
//   Ports
//     clk                in   system clock
//     rst                in   synchronous, active-high reset
//     entry_en           in   1 = accepted keys modify the buffer
//     clr                in   synchronous buffer clear (wins over a key)
//     key_row_n[3:0]     in   keypad rows, active-low, asynchronous
//     key_col_n[3:0]     out  column drive, active-low, exactly one low
//     user_input[15:0]   out  4 BCD digits, [15:12] oldest .. [3:0] newest
//     digit_count[2:0]   out  digits held, 0..4
//     data_update_pulse  out  1-cycle strobe when user_input/digit_count change
//     enter_pulse        out  1-cycle strobe on '#'
//     code_full          out  digit_count == 4
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   SCAN     | drive col_idx for SCAN_DIV cycles, then sample the rows
//   DEBOUNCE | latched row must stay low DEBOUNCE_CYCLES cycles
//   ACCEPT   | one cycle: apply the key to the buffer
//   RELEASE  | all rows must stay high DEBOUNCE_CYCLES cycles
module keypad_code_entry #(
    parameter int SCAN_DIV        = 16,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        entry_en,
    input  logic        clr,
    input  logic [3:0]  key_row_n,
    output logic [3:0]  key_col_n,
    output logic [15:0] user_input,
    output logic [2:0]  digit_count,
    output logic        data_update_pulse,
    output logic        enter_pulse,
    output logic        code_full
);

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_ACCEPT   = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    localparam logic [1:0] K_NONE  = 2'd0;
    localparam logic [1:0] K_DIGIT = 2'd1;
    localparam logic [1:0] K_STAR  = 2'd2;
    localparam logic [1:0] K_HASH  = 2'd3;

    // Timer is a down-counter; the terminal count (zero) marks the last
    // cycle of a dwell or debounce window.
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_LOAD   = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       row_meta;
    logic [3:0]       row_sync;
    logic [1:0]       state;
    logic [1:0]       col_idx;
    logic [1:0]       key_row;
    logic [CNT_W-1:0] timer;
    logic             row_any_low;
    logic [1:0]       low_idx;
    logic [1:0]       key_kind;
    logic [3:0]       key_digit;
    logic             accept;

    assign key_col_n   = ~(4'b0001 << col_idx);
    assign row_any_low = ~&row_sync;
    assign code_full   = (digit_count == 3'd4);
    assign accept      = (state == ST_ACCEPT) && entry_en;

    // Lowest-index low row wins when several keys in a column are down.
    always_comb begin
        low_idx = 2'd3;
        if (!row_sync[0])      low_idx = 2'd0;
        else if (!row_sync[1]) low_idx = 2'd1;
        else if (!row_sync[2]) low_idx = 2'd2;
    end

    always_comb begin
        key_kind  = K_NONE;
        key_digit = 4'd0;
        case ({key_row, col_idx})
            4'b00_00: begin key_kind = K_DIGIT; key_digit = 4'd1; end
            4'b00_01: begin key_kind = K_DIGIT; key_digit = 4'd2; end
            4'b00_10: begin key_kind = K_DIGIT; key_digit = 4'd3; end
            4'b01_00: begin key_kind = K_DIGIT; key_digit = 4'd4; end
            4'b01_01: begin key_kind = K_DIGIT; key_digit = 4'd5; end
            4'b01_10: begin key_kind = K_DIGIT; key_digit = 4'd6; end
            4'b10_00: begin key_kind = K_DIGIT; key_digit = 4'd7; end
            4'b10_01: begin key_kind = K_DIGIT; key_digit = 4'd8; end
            4'b10_10: begin key_kind = K_DIGIT; key_digit = 4'd9; end
            4'b11_00: key_kind = K_STAR;
            4'b11_01: begin key_kind = K_DIGIT; key_digit = 4'd0; end
            4'b11_10: key_kind = K_HASH;
            default:  key_kind = K_NONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= key_row_n;
            row_sync <= row_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_SCAN;
            col_idx <= 2'd0;
            key_row <= 2'd0;
            timer   <= DWELL_LOAD;
        end else begin
            case (state)
                ST_SCAN: begin
                    if (timer == '0) begin
                        if (row_any_low) begin
                            key_row <= low_idx;
                            timer   <= DEB_LOAD;
                            state   <= ST_DEBOUNCE;
                        end else begin
                            col_idx <= col_idx + 2'd1;
                            timer   <= DWELL_LOAD;
                        end
                    end else begin
                        timer <= timer - CNT_W'(1);
                    end
                end
                ST_DEBOUNCE: begin
                    // A bounce back to high abandons the press; the column is
                    // kept so the same key is picked up again on the next dwell.
                    if (row_sync[key_row]) begin
                        timer <= DWELL_LOAD;
                        state <= ST_SCAN;
                    end else if (timer == '0) begin
                        state <= ST_ACCEPT;
                    end else begin
                        timer <= timer - CNT_W'(1);
                    end
                end
                ST_ACCEPT: begin
                    timer <= DEB_LOAD;
                    state <= ST_RELEASE;
                end
                default: begin
                    if (row_any_low) begin
                        timer <= DEB_LOAD;
                    end else if (timer == '0) begin
                        timer <= DWELL_LOAD;
                        state <= ST_SCAN;
                    end else begin
                        timer <= timer - CNT_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            user_input        <= '0;
            digit_count       <= '0;
            data_update_pulse <= 1'b0;
            enter_pulse       <= 1'b0;
        end else begin
            data_update_pulse <= 1'b0;
            // '#' still reports a submit even if clr discards the buffer update.
            enter_pulse       <= accept && (key_kind == K_HASH);
            if (clr) begin
                user_input        <= '0;
                digit_count       <= '0;
                data_update_pulse <= 1'b1;
            end else if (accept) begin
                case (key_kind)
                    K_DIGIT: begin
                        if (digit_count != 3'd4) begin
                            user_input        <= {user_input[11:0], key_digit};
                            digit_count       <= digit_count + 3'd1;
                            data_update_pulse <= 1'b1;
                        end
                    end
                    K_STAR: begin
`ifdef KEYPAD_BACKSPACE_EN
                        if (digit_count != 3'd0) begin
                            user_input        <= {4'd0, user_input[15:4]};
                            digit_count       <= digit_count - 3'd1;
                            data_update_pulse <= 1'b1;
                        end
`else
                        user_input        <= '0;
                        digit_count       <= '0;
                        data_update_pulse <= 1'b1;
`endif
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_code_entry.sv
module tb_keypad_code_entry;

    localparam int CYCLE_LIMIT = 60000;

    logic        clk;
    logic        rst;
    logic        entry_en;
    logic        clr;
    logic [3:0]  key_row_n;
    logic [3:0]  key_col_n;
    logic [15:0] user_input;
    logic [2:0]  digit_count;
    logic        data_update_pulse;
    logic        enter_pulse;
    logic        code_full;

    keypad_code_entry #(
        .SCAN_DIV(4),
        .DEBOUNCE_CYCLES(8),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .entry_en(entry_en),
        .clr(clr),
        .key_row_n(key_row_n),
        .key_col_n(key_col_n),
        .user_input(user_input),
        .digit_count(digit_count),
        .data_update_pulse(data_update_pulse),
        .enter_pulse(enter_pulse),
        .code_full(code_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical keypad: the held key pulls its row low while its column is driven.
    logic       k_down;
    logic [1:0] k_row;
    logic [1:0] k_col;
    assign key_row_n = (k_down && !key_col_n[k_col]) ? ~(4'b0001 << k_row) : 4'b1111;

    string keys = "123A456B789C*0#D";

    int errors = 0;
    int checks = 0;
    int cycles = 0;
    int upd_total = 0;
    int ent_total = 0;
    bit model_valid = 0;
    bit have_prev = 0;
    logic [15:0] prev_ui;
    logic [2:0]  prev_dc;
    int m_dig[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycles);
        end
    endtask

    function automatic int model_ui();
        int v;
        v = 0;
        foreach (m_dig[i]) v = v * 16 + m_dig[i];
        return v;
    endfunction

    // Expected effect of one accepted key: buffer update plus pulse counts.
    task automatic model_apply(input int id, input bit en, output int eu, output int ee);
        byte c;
        c  = keys[id];
        eu = 0;
        ee = 0;
        if (en) begin
            if (c >= "0" && c <= "9") begin
                if (m_dig.size() < 4) begin
                    m_dig.push_back(int'(c) - 48);
                    eu = 1;
                end
            end else if (c == "*") begin
`ifdef KEYPAD_BACKSPACE_EN
                if (m_dig.size() > 0) begin
                    void'(m_dig.pop_back());
                    eu = 1;
                end
`else
                m_dig.delete();
                eu = 1;
`endif
            end else if (c == "#") begin
                ee = 1;
            end
        end
    endtask

    task automatic tick();
        logic rst_before;
        rst_before = rst;
        @(negedge clk);
        cycles++;
        if (cycles > CYCLE_LIMIT) begin
            $display("FAIL cycle_budget: got %0d cycles limit %0d", cycles, CYCLE_LIMIT);
            $fatal(1, "cycle budget exhausted");
        end
        chk("col_one_low", $countones(~key_col_n), 1);
        if (model_valid) begin
            chk("model_ui", int'(user_input), model_ui());
            chk("model_cnt", int'(digit_count), m_dig.size());
            chk("model_full", int'(code_full), int'(m_dig.size() == 4));
            chk("idle_pulses", int'({data_update_pulse, enter_pulse}), 0);
        end
        if (have_prev && !rst_before && (user_input != prev_ui || digit_count != prev_dc))
            chk("change_has_pulse", int'(data_update_pulse), 1);
        if (data_update_pulse) upd_total++;
        if (enter_pulse) ent_total++;
        prev_ui   = user_input;
        prev_dc   = digit_count;
        have_prev = 1;
    endtask

    task automatic do_reset();
        model_valid = 0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        m_dig.delete();
    endtask

    task automatic do_key(input int id, input bit en, input string tag);
        int u0, e0, eu, ee;
        model_valid = 0;
        entry_en = en;
        u0 = upd_total;
        e0 = ent_total;
        k_row = 2'(id / 4);
        k_col = 2'(id % 4);
        k_down = 1'b1;
        repeat (50) tick();
        k_down = 1'b0;
        repeat (30) tick();
        model_apply(id, en, eu, ee);
        chk({tag, "_upd"}, upd_total - u0, eu);
        chk({tag, "_ent"}, ent_total - e0, ee);
        model_valid = 1;
        tick();
    endtask

    task automatic do_clr(input string tag);
        int u0;
        model_valid = 0;
        u0 = upd_total;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        m_dig.delete();
        chk({tag, "_upd"}, upd_total - u0, 1);
        model_valid = 1;
        tick();
    endtask

    initial begin
        int u0, e0, eu, ee, n;
        int n_before, n_at, n_after, n_bad;

        rst = 1'b1;
        entry_en = 1'b0;
        clr = 1'b0;
        k_down = 1'b0;
        k_row = 2'd0;
        k_col = 2'd0;
        tick();
        chk("rst_col", int'(key_col_n), 'he);
        chk("rst_ui", int'(user_input), 0);
        chk("rst_cnt", int'(digit_count), 0);
        chk("rst_pulses", int'({data_update_pulse, enter_pulse}), 0);
        do_reset();
        model_valid = 1;

        // 1: four clean digits
        u0 = upd_total;
        do_key(0, 1, "t1_k1");
        do_key(1, 1, "t1_k2");
        do_key(2, 1, "t1_k3");
        do_key(4, 1, "t1_k4");
        chk("t1_ui", int'(user_input), 'h1234);
        chk("t1_cnt", int'(digit_count), 4);
        chk("t1_full", int'(code_full), 1);
        chk("t1_pulses", upd_total - u0, 4);

        // 2: digit on a full buffer, then '#'
        do_key(5, 1, "t2_k5");
        chk("t2_ui", int'(user_input), 'h1234);
        e0 = ent_total;
        do_key(14, 1, "t2_hash");
        chk("t2_enter", ent_total - e0, 1);
        chk("t2_ui_after_hash", int'(user_input), 'h1234);

        // 3: bouncing '7', then held long with no repeat
        do_clr("t3_clr");
        model_valid = 0;
        u0 = upd_total;
        k_row = 2'd2;
        k_col = 2'd0;
        for (int i = 0; i < 3; i++) begin
            k_down = 1'b1;
            repeat (5) tick();
            k_down = 1'b0;
            repeat (3) tick();
        end
        k_down = 1'b1;
        repeat (250) tick();
        k_down = 1'b0;
        repeat (30) tick();
        model_apply(8, 1, eu, ee);
        chk("t3_one_accept", upd_total - u0, 1);
        chk("t3_ui", int'(user_input), 'h0007);
        model_valid = 1;
        tick();

        // 4: '*' after 0012
        do_clr("t4_clr");
        do_key(0, 1, "t4_k1");
        do_key(1, 1, "t4_k2");
        chk("t4_pre", int'(user_input), 'h0012);
        do_key(12, 1, "t4_star");
`ifdef KEYPAD_BACKSPACE_EN
        chk("t4_ui", int'(user_input), 'h0001);
        chk("t4_cnt", int'(digit_count), 1);
        do_key(12, 1, "t4_star2");
        u0 = upd_total;
        do_key(12, 1, "t4_star_empty");
        chk("t4_empty_nopulse", upd_total - u0, 0);
`else
        chk("t4_ui", int'(user_input), 'h0000);
        chk("t4_cnt", int'(digit_count), 0);
`endif
        do_clr("t4_clr_empty");

        // 5: '9' with entry disabled, then clr swept across the accept cycle
        do_key(10, 0, "t5_disabled");
        chk("t5_dis_ui", int'(user_input), 0);
        n_before = 0; n_at = 0; n_after = 0; n_bad = 0;
        for (int k = 0; k < 36; k++) begin
            do_reset();
            entry_en = 1'b1;
            u0 = upd_total;
            k_row = 2'd2;
            k_col = 2'd2;
            k_down = 1'b1;
            for (int t = 0; t < 70; t++) begin
                clr = (t == k);
                tick();
            end
            clr = 1'b0;
            k_down = 1'b0;
            repeat (30) tick();
            n = upd_total - u0;
            if (user_input == 16'h0009 && digit_count == 3'd1 && n == 2) n_before++;
            else if (user_input == 16'h0000 && digit_count == 3'd0 && n == 1) n_at++;
            else if (user_input == 16'h0000 && digit_count == 3'd0 && n == 2) n_after++;
            else n_bad++;
        end
        chk("t5_sweep_bad", n_bad, 0);
        chk("t5_clr_wins_once", n_at, 1);
        chk("t5_before_seen", int'(n_before > 0), 1);
        chk("t5_after_seen", int'(n_after > 0), 1);
        for (int k = 0; k < 36; k++) begin
            do_reset();
            entry_en = 1'b1;
            u0 = upd_total;
            e0 = ent_total;
            k_row = 2'd3;
            k_col = 2'd2;
            k_down = 1'b1;
            for (int t = 0; t < 70; t++) begin
                clr = (t == k);
                tick();
            end
            clr = 1'b0;
            k_down = 1'b0;
            repeat (30) tick();
            chk("t5_hash_clr_upd", upd_total - u0, 1);
            chk("t5_hash_clr_ent", ent_total - e0, 1);
        end
        do_reset();
        model_valid = 1;
        tick();

        // 6: reset while a key is being debounced
        do_key(5, 1, "t6_k5");
        do_key(6, 1, "t6_k6");
        chk("t6_pre", int'(user_input), 'h0056);
        model_valid = 0;
        u0 = upd_total;
        k_row = 2'd0;
        k_col = 2'd0;
        k_down = 1'b1;
        n = 0;
        while (key_col_n != 4'b1110 && n < 40) begin
            tick();
            n++;
        end
        chk("t6_col0_reached", int'(n < 40), 1);
        repeat (6) tick();
        rst = 1'b1;
        tick();
        chk("t6_rst_col", int'(key_col_n), 'he);
        chk("t6_rst_ui", int'(user_input), 0);
        chk("t6_rst_cnt", int'(digit_count), 0);
        chk("t6_rst_pulse", int'(data_update_pulse), 0);
        rst = 1'b0;
        m_dig.delete();
        repeat (50) tick();
        k_down = 1'b0;
        repeat (30) tick();
        model_apply(0, 1, eu, ee);
        chk("t6_one_accept", upd_total - u0, 1);
        chk("t6_ui", int'(user_input), 'h0001);
        model_valid = 1;
        tick();

        // Random key/clr traffic against the model
        for (int r = 0; r < 80; r++) begin
            if ($urandom_range(0, 9) == 0) do_clr("rnd_clr");
            else do_key(int'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), "rnd_key");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
